// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle between two writeback requesters, the arbiter and the register file write port.
// The master side presents requests and observes grants; the slave side is the arbiter itself.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [DATA_WIDTH-1:0] req1_data;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  starved;

  modport master (
    output req0_valid, req0_address, req0_data,
    output req1_valid, req1_address, req1_data,
    input  req0_ready, req1_ready,
    input  write_address, write_data, write_enable, starved
  );

  modport slave (
    input  req0_valid, req0_address, req0_data,
    input  req1_valid, req1_address, req1_data,
    output req0_ready, req1_ready,
    output write_address, write_data, write_enable, starved
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between the in-order writeback (priority) and a
// long-latency unit, with a bounded-wait forced grant and a one-cycle registered write stage.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  write_enable_q, write_enable_d;
  logic                  force_grant;
  logic                  grant0;
  logic                  grant1;

  // Grant stage: combinational arbitration, gated off while reset is held
  always_comb begin
    force_grant = (wait_cnt_q == MAX_WAIT_C);
    grant1      = rst && bus.req1_valid && (force_grant || !bus.req0_valid);
    grant0      = rst && bus.req0_valid && !(force_grant && bus.req1_valid);

    wait_cnt_d = wait_cnt_q;
    if (!bus.req1_valid || grant1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    write_enable_d  = 1'b0;
    if (grant1) begin
      write_address_d = bus.req1_address;
      write_data_d    = bus.req1_data;
      write_enable_d  = (bus.req1_address != '0);
    end else if (grant0) begin
      write_address_d = bus.req0_address;
      write_data_d    = bus.req0_data;
      write_enable_d  = (bus.req0_address != '0);
    end
  end

  // Write stage: registered register-file port, cleared asynchronously so a staged write is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q      <= 4'd0;
      write_address_q <= '0;
      write_data_q    <= '0;
      write_enable_q  <= 1'b0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_enable_q  <= write_enable_d;
    end
  end

  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.starved       = force_grant && bus.req1_valid;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.write_enable  = write_enable_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters. Requester 0 is the in-order pipeline writeback; requester 1 is a long-latency unit such as a load or divide unit. Fixed priority goes to requester 0, with a starvation counter that forces a grant to requester 1 after a bounded wait. The block drives the register file's write_address / write_data / write_enable from a registered output stage.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register address.
- MAX_WAIT, 3, max consecutive cycles requester 1 may be valid and ungranted before a forced grant; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 granted this cycle (combinational).
- req0_address  in  ADDR_WIDTH  destination register of requester 0.
- req0_data  in  DATA_WIDTH  write value of requester 0.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 granted this cycle (combinational).
- req1_address  in  ADDR_WIDTH  destination register of requester 1.
- req1_data  in  DATA_WIDTH  write value of requester 1.
- write_address  out  ADDR_WIDTH  to register file write port.
- write_data  out  DATA_WIDTH  to register file write port.
- write_enable  out  1  to register file write port.
- starved  out  1  high while the forced grant to requester 1 is active (debug/perf).

Behaviour:
- Reset (rst low, async): write_enable=0, write_address=0, write_data=0, wait_cnt=0. req0_ready and req1_ready evaluate to 0 while rst is low.
- Handshake: a transfer occurs on a rising edge when valid && ready. The requester holds valid, address and data stable until the transfer. Ready may depend on valid; valid never depends on ready.
- At most one ready is high per cycle; ready is never high without the matching valid.
- Grant rule, evaluated each cycle:
  - force = (wait_cnt == MAX_WAIT).
  - If force && req1_valid: grant 1.
  - Else if req0_valid: grant 0.
  - Else if req1_valid: grant 1.
  - Else: no grant.
- wait_cnt, width 4:
  - Cleared when req1 is granted or req1_valid=0.
  - Incremented when req1_valid=1 and not granted.
  - Saturates at MAX_WAIT; never exceeds it.
- starved = force && req1_valid.
- Output stage, latency 1 cycle from handshake to write port:
  - On a grant, the next edge loads write_address and write_data from the winner.
  - write_enable is set to 1 only if the winner's address != 0.
  - A write to x0 is accepted (ready=1) and dropped: write_enable=0.
  - With no grant: write_enable=0; write_address and write_data hold their last values.
- Back-to-back: a new grant is allowed every cycle. The output stage has no backpressure; the register file accepts every write.
- Same address from both requesters in consecutive cycles: writes land in grant order, so the later grant wins in the register file.
- Both valid with the same address in one cycle: only the winner is granted; the loser stays pending and writes later, so its value ends up final.
- Reset asserted mid-operation:
  - Outputs clear immediately without waiting for a clock.
  - A write staged in the output register is lost.
  - Requesters see ready=0 and must re-present after reset release.
- Reset release: the first grant is possible in the first clock edge after rst goes high.
- Bench assertions:
  - Onehot0 of {req0_ready, req1_ready}.
  - Requester 1 never waits more than MAX_WAIT+1 cycles while continuously valid.
  - write_enable implies write_address != 0.

Test Plan:
- Single write: req0_valid=1, addr=5, data=0xDEADBEEF for one cycle -> req0_ready=1 same cycle; next cycle write_enable=1, write_address=5, write_data=0xDEADBEEF; following cycle write_enable=0.
- Starvation bound (MAX_WAIT=3): both valid continuously, req0 address 1..n, req1 addr=7 data=0x1234 -> req0 granted cycles 0,1,2; cycle 3 starved=1 and req1_ready=1; write_address=7 appears at cycle 4; wait_cnt returns to 0.
- Requester 1 alone: req1_valid=1, addr=10, data=0xA5A5A5A5 -> req1_ready=1 immediately; write lands next cycle; starved never asserts.
- x0 drop: req0_valid=1, addr=0, data=0xFFFFFFFF -> req0_ready=1; write_enable stays 0 the next cycle.
- Async reset mid-stream: assert rst low between edges while write_enable=1 -> write_enable=0 and both readies=0 before the next edge; after release, a req0 write to addr 3 completes with 1-cycle latency.
- Same-address ordering: req0 addr=4 data=1 and req1 addr=4 data=2 both valid -> cycle 0 writes 1, cycle 1 writes 2; final register-file x4 = 2.
